// File: rtl/risc16_mem_initiator_if.sv
// Bus bundle between the RiSC-16 core, the memory initiator and the byte-wide
// memory array. The master modport is taken by the initiator: it accepts core
// requests and drives the memory port. The slave modport is the environment,
// meaning the core request side plus the memory array.
interface risc16_mem_initiator_if #(
    parameter int WORD_LENGTH = 16,
    parameter int BYTE_LENGTH = 8,
    parameter int ADDR_LENGTH = 16
);
    logic                   reqValid;
    logic                   reqReady;
    logic                   reqWrite;
    logic [ADDR_LENGTH-1:0] reqAddr;
    logic [WORD_LENGTH-1:0] reqWData;
    logic                   respValid;
    logic [WORD_LENGTH-1:0] respData;
    logic                   respError;
    logic [ADDR_LENGTH-1:0] memAddr;
    logic [BYTE_LENGTH-1:0] memWData;
    logic [BYTE_LENGTH-1:0] memRData;
    logic                   memWriteEn;

    modport master (
        input  reqValid, reqWrite, reqAddr, reqWData, memRData,
        output reqReady, respValid, respData, respError,
        output memAddr, memWData, memWriteEn
    );

    modport slave (
        output reqValid, reqWrite, reqAddr, reqWData, memRData,
        input  reqReady, respValid, respData, respError,
        input  memAddr, memWData, memWriteEn
    );
endinterface

// File: rtl/risc16_mem_initiator.sv
// RiSC-16 memory initiator. Each 16-bit load or store becomes two byte
// transfers, big-endian: the high byte goes to addr and the low byte goes to
// addr+1, with the address wrapping. Every memory-side output is registered
// on posedge, so the memory sees stable values at its negedge write strobe.
// Optional build macro: RISC16_MEM_ALIGN_CHECK_EN. When it is defined, an odd
// address is rejected with respError and no memory transfer takes place.
module risc16_mem_initiator #(
    parameter int WORD_LENGTH = 16,
    parameter int BYTE_LENGTH = 8,
    parameter int ADDR_LENGTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    risc16_mem_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_write;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic [BYTE_LENGTH-1:0] r_wdata_lo;
    logic [BYTE_LENGTH-1:0] r_data_hi;
    logic                   r_reqReady;
    logic                   r_respValid;
    logic [WORD_LENGTH-1:0] r_respData;
    logic                   r_respError;
    logic [ADDR_LENGTH-1:0] r_memAddr;
    logic [BYTE_LENGTH-1:0] r_memWData;
    logic                   r_memWriteEn;

    logic                   w_write_nxt;
    logic [ADDR_LENGTH-1:0] w_addr_nxt;
    logic [BYTE_LENGTH-1:0] w_wdata_lo_nxt;
    logic [BYTE_LENGTH-1:0] w_data_hi_nxt;
    logic                   w_respValid_nxt;
    logic [WORD_LENGTH-1:0] w_respData_nxt;
    logic                   w_respError_nxt;
    logic [ADDR_LENGTH-1:0] w_memAddr_nxt;
    logic [BYTE_LENGTH-1:0] w_memWData_nxt;
    logic                   w_memWriteEn_nxt;
    logic                   w_misaligned;

`ifdef RISC16_MEM_ALIGN_CHECK_EN
    assign w_misaligned = bus.reqAddr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    // State register. Reset returns the FSM to IDLE from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, plus the next values of every registered output and
    // latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_write_nxt      = r_write;
        w_addr_nxt       = r_addr;
        w_wdata_lo_nxt   = r_wdata_lo;
        w_data_hi_nxt    = r_data_hi;
        w_respValid_nxt  = 1'b0;
        w_respData_nxt   = r_respData;
        w_respError_nxt  = r_respError;
        w_memAddr_nxt    = r_memAddr;
        w_memWData_nxt   = r_memWData;
        w_memWriteEn_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.reqValid && r_reqReady) begin
                    w_write_nxt    = bus.reqWrite;
                    w_addr_nxt     = bus.reqAddr;
                    w_wdata_lo_nxt = bus.reqWData[BYTE_LENGTH-1:0];
                    if (w_misaligned) begin
                        w_state_nxt     = RESP;
                        w_respValid_nxt = 1'b1;
                        w_respError_nxt = 1'b1;
                        w_respData_nxt  = '0;
                    end else begin
                        w_state_nxt      = HI;
                        w_memAddr_nxt    = bus.reqAddr;
                        w_memWData_nxt   = bus.reqWData[WORD_LENGTH-1:BYTE_LENGTH];
                        w_memWriteEn_nxt = bus.reqWrite;
                    end
                end
            end
            HI: begin
                if (!r_write) begin
                    w_data_hi_nxt = bus.memRData;
                end
                w_memAddr_nxt    = r_addr + ADDR_LENGTH'(1);
                w_memWData_nxt   = r_wdata_lo;
                w_memWriteEn_nxt = r_write;
                w_state_nxt      = LO;
            end
            LO: begin
                // The low byte goes straight into the response word. The
                // response is already registered, so a separate low-byte
                // latch would only duplicate it.
                w_respValid_nxt = 1'b1;
                w_respError_nxt = 1'b0;
                w_respData_nxt  = r_write ? '0 : {r_data_hi, bus.memRData};
                w_state_nxt     = RESP;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath latches and registered outputs. An asynchronous reset drops
    // memWriteEn immediately, which aborts an access that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata_lo   <= '0;
            r_data_hi    <= '0;
            r_reqReady   <= 1'b1;
            r_respValid  <= 1'b0;
            r_respData   <= '0;
            r_respError  <= 1'b0;
            r_memAddr    <= '0;
            r_memWData   <= '0;
            r_memWriteEn <= 1'b0;
        end else begin
            r_write      <= w_write_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata_lo   <= w_wdata_lo_nxt;
            r_data_hi    <= w_data_hi_nxt;
            r_reqReady   <= (w_state_nxt == IDLE);
            r_respValid  <= w_respValid_nxt;
            r_respData   <= w_respData_nxt;
            r_respError  <= w_respError_nxt;
            r_memAddr    <= w_memAddr_nxt;
            r_memWData   <= w_memWData_nxt;
            r_memWriteEn <= w_memWriteEn_nxt;
        end
    end

    assign bus.reqReady   = r_reqReady;
    assign bus.respValid  = r_respValid;
    assign bus.respData   = r_respData;
    assign bus.respError  = r_respError;
    assign bus.memAddr    = r_memAddr;
    assign bus.memWData   = r_memWData;
    assign bus.memWriteEn = r_memWriteEn;

endmodule

// File: tb/tb_risc16_mem_initiator.sv
// Testbench for risc16_mem_initiator. A table of directed load/store vectors
// is followed by hand-written back-to-back and reset-abort sequences. The
// expected values depend on whether RISC16_MEM_ALIGN_CHECK_EN is defined.
module tb_risc16_mem_initiator;

    logic clk;
    logic rst;

    risc16_mem_initiator_if #(
        .WORD_LENGTH(16),
        .BYTE_LENGTH(8),
        .ADDR_LENGTH(16)
    ) bus ();

    risc16_mem_initiator #(
        .WORD_LENGTH(16),
        .BYTE_LENGTH(8),
        .ADDR_LENGTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic       mem_init_done = 1'b0;
    int         n_writes = 0;
    int         mon_bad = 0;
    int         tests = 0;
    int         failed = 0;

    assign bus.memRData = mem[bus.memAddr];

    // Byte memory model: it clears itself once, then takes writes on negedge.
    // Writes are legal only while the initiator is busy, i.e. reqReady is low.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'h00;
            mem_init_done = 1'b1;
        end
        if (bus.memWriteEn) begin
            mem[bus.memAddr] = bus.memWData;
            n_writes = n_writes + 1;
            if (bus.reqReady) mon_bad = mon_bad + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request, starting one time unit after a posedge while the
    // DUT is idle. lat counts cycles from the accepting edge to respValid,
    // and pulse is respValid one cycle after that.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rdata, output logic err,
                          output int lat, output logic pulse, output logic [15:0] held);
        int guard;
        bus.reqValid = 1'b1;
        bus.reqWrite = w;
        bus.reqAddr  = a;
        bus.reqWData = d;
        guard = 0;
        while (!bus.reqReady && guard < 16) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = '0;
        bus.reqWData = '0;
        lat = 1;
        while (!bus.respValid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus.respData;
        err   = bus.respError;
        @(posedge clk); #1;
        pulse = bus.respValid;
        held  = bus.respData;
    endtask

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_lat;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_writes;
        logic        chk_mem;
        logic [15:0] ma0;
        logic [7:0]  eb0;
        logic [15:0] ma1;
        logic [7:0]  eb1;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    initial begin
        logic [15:0] rdata;
        logic [15:0] held;
        logic        err;
        logic        pulse;
        int          lat;
        int          w0;
        int          bad;
        logic [7:0]  exp_ready;
        logic [7:0]  exp_resp;

        vec[0] = '{1'b1, 16'h0010, 16'hBEEF, 3, 16'h0000, 1'b0, 2, 1'b1, 16'h0010, 8'hBE, 16'h0011, 8'hEF};
        vec[1] = '{1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[4] = '{1'b1, 16'h0020, 16'hA55A, 3, 16'h0000, 1'b0, 2, 1'b1, 16'h0020, 8'hA5, 16'h0021, 8'h5A};
        vec[5] = '{1'b0, 16'h0020, 16'h0000, 3, 16'hA55A, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
`ifdef RISC16_MEM_ALIGN_CHECK_EN
        vec[2]  = '{1'b1, 16'hFFFF, 16'h1234, 1, 16'h0000, 1'b1, 0, 1'b1, 16'hFFFF, 8'h00, 16'h0000, 8'h00};
        vec[3]  = '{1'b0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[6]  = '{1'b0, 16'h0011, 16'h0000, 1, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[7]  = '{1'b0, 16'h0000, 16'h0000, 3, 16'h0000, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[8]  = '{1'b1, 16'h0011, 16'h7788, 1, 16'h0000, 1'b1, 0, 1'b1, 16'h0011, 8'hEF, 16'h0012, 8'h00};
        vec[9]  = '{1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[10] = '{1'b0, 16'h0012, 16'h0000, 3, 16'h0000, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
`else
        vec[2]  = '{1'b1, 16'hFFFF, 16'h1234, 3, 16'h0000, 1'b0, 2, 1'b1, 16'hFFFF, 8'h12, 16'h0000, 8'h34};
        vec[3]  = '{1'b0, 16'hFFFF, 16'h0000, 3, 16'h1234, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[6]  = '{1'b0, 16'h0011, 16'h0000, 3, 16'hEF00, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[7]  = '{1'b0, 16'h0000, 16'h0000, 3, 16'h3400, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[8]  = '{1'b1, 16'h0011, 16'h7788, 3, 16'h0000, 1'b0, 2, 1'b1, 16'h0011, 8'h77, 16'h0012, 8'h88};
        vec[9]  = '{1'b0, 16'h0010, 16'h0000, 3, 16'hBE77, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vec[10] = '{1'b0, 16'h0012, 16'h0000, 3, 16'h8800, 1'b0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
`endif

        // Reset values are checked while reset is asserted, before any clock edge.
        rst          = 1'b1;
        bus.reqValid = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = '0;
        bus.reqWData = '0;
        #2;
        check("rst_reqReady",   32'(bus.reqReady),   32'd1);
        check("rst_respValid",  32'(bus.respValid),  32'd0);
        check("rst_respData",   32'(bus.respData),   32'd0);
        check("rst_respError",  32'(bus.respError),  32'd0);
        check("rst_memAddr",    32'(bus.memAddr),    32'd0);
        check("rst_memWData",   32'(bus.memWData),   32'd0);
        check("rst_memWriteEn", 32'(bus.memWriteEn), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            w0 = n_writes;
            do_req(vec[i].write, vec[i].addr, vec[i].wdata, rdata, err, lat, pulse, held);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vec[i].exp_lat));
            check($sformatf("v%0d_respData", i), 32'(rdata), 32'(vec[i].exp_data));
            check($sformatf("v%0d_respError", i), 32'(err), 32'(vec[i].exp_err));
            check($sformatf("v%0d_pulse_width", i), 32'(pulse), 32'd0);
            check($sformatf("v%0d_respData_hold", i), 32'(held), 32'(vec[i].exp_data));
            check($sformatf("v%0d_byte_writes", i), 32'(n_writes - w0), 32'(vec[i].exp_writes));
            check($sformatf("v%0d_reqReady_after", i), 32'(bus.reqReady), 32'd1);
            if (vec[i].chk_mem) begin
                check($sformatf("v%0d_mem_%0h", i, vec[i].ma0), 32'(mem[vec[i].ma0]), 32'(vec[i].eb0));
                check($sformatf("v%0d_mem_%0h", i, vec[i].ma1), 32'(mem[vec[i].ma1]), 32'(vec[i].eb1));
            end
        end

        // Back-to-back: reqValid is held high across two loads from 0x0020.
        // After each accepting edge reqReady stays low for 3 cycles and
        // respValid pulses in the third of them.
        exp_ready = 8'b1000_1000;
        exp_resp  = 8'b0100_0100;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = 16'h0020;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 4) bus.reqValid = 1'b0;
            check($sformatf("b2b_reqReady_%0d", k), 32'(bus.reqReady), 32'(exp_ready[k]));
            check($sformatf("b2b_respValid_%0d", k), 32'(bus.respValid), 32'(exp_resp[k]));
            if (exp_resp[k]) check($sformatf("b2b_respData_%0d", k), 32'(bus.respData), 32'h0000A55A);
        end
        bus.reqAddr = '0;

        // Reset during the HI phase of a store: the write enable drops
        // immediately, and no byte is written and no response is produced.
        w0 = n_writes;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b1;
        bus.reqAddr  = 16'h0040;
        bus.reqWData = 16'hCAFE;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        check("hi_memWriteEn", 32'(bus.memWriteEn), 32'd1);
        check("hi_memAddr",    32'(bus.memAddr),    32'h00000040);
        check("hi_memWData",   32'(bus.memWData),   32'h000000CA);
        check("hi_reqReady",   32'(bus.reqReady),   32'd0);
        #1 rst = 1'b1;
        #1;
        check("abort_memWriteEn", 32'(bus.memWriteEn), 32'd0);
        check("abort_reqReady",   32'(bus.reqReady),   32'd1);
        check("abort_respValid",  32'(bus.respValid),  32'd0);
        #1 rst = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = '0;
        bus.reqWData = '0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.respValid !== 1'b0) bad++;
        end
        check("abort_no_response", 32'(bad), 32'd0);
        check("abort_no_writes",   32'(n_writes - w0), 32'd0);
        check("abort_mem_0040",    32'(mem[16'h0040]), 32'd0);
        check("abort_mem_0041",    32'(mem[16'h0041]), 32'd0);
        check("abort_idle_ready",  32'(bus.reqReady), 32'd1);

        check("we_only_while_busy", 32'(mon_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/risc16_mem_initiator.md
Name: risc16_mem_initiator

Overview:
- Initiator side of the RiSC-16 byte-addressed memory interface.
- Accepts 16-bit load/store requests from the core over a valid/ready handshake.
- Performs each access as two byte transfers on an 8-bit memory port: the high byte at addr, then the low byte at addr+1 (big-endian).
- Returns one response per request. Sits between the core datapath and the byte-wide memory array.

Parameters:
- WORD_LENGTH, 16, core word width; must be 2*BYTE_LENGTH.
- BYTE_LENGTH, 8, memory port data width.
- ADDR_LENGTH, 16, address width; addresses wrap modulo 2^ADDR_LENGTH.

Ports:
- clk  in  1  clock. Core side updates on posedge; memory samples writes on negedge.
- rst  in  1  asynchronous, active-high reset.
- reqValid  in  1  core request valid.
- reqReady  out  1  initiator can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqAddr  in  ADDR_LENGTH  byte address of the word.
- reqWData  in  WORD_LENGTH  store data.
- respValid  out  1  one-cycle pulse: request complete.
- respData  out  WORD_LENGTH  load data; 0 for stores.
- respError  out  1  misaligned access flag (see Optional Feature).
- memAddr  out  ADDR_LENGTH  memory byte address.
- memWData  out  BYTE_LENGTH  memory write byte.
- memRData  in  BYTE_LENGTH  memory read byte (combinational from memAddr).
- memWriteEn  out  1  memory write enable.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state=IDLE, reqReady=1, respValid=0, respData=0, respError=0
  - memAddr=0, memWData=0, memWriteEn=0
  - all internal latches = 0
- All memory-side outputs are registered and change only on posedge, so they are stable at the memory's negedge.
- FSM states are IDLE, HI, LO, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid&&reqReady at posedge: latch addr, wdata and write flag; go to HI.
  - Drive memAddr=reqAddr, memWData=reqWData[15:8], memWriteEn=reqWrite.
- HI:
  - Memory sees the high-byte access.
  - At posedge, loads capture memRData into data[15:8].
  - Next: memAddr=addr+1 (0xFFFF wraps to 0x0000), memWData=wdata[7:0], memWriteEn=write; go to LO.
- LO:
  - Memory sees the low-byte access.
  - At posedge, loads capture memRData into data[7:0].
  - memWriteEn returns to 0; go to RESP.
- RESP:
  - respValid=1 for exactly one cycle.
  - respData = captured word for loads, 0 for stores.
  - Go to IDLE.
- Latency: request accept to respValid = 3 cycles.
- Throughput: one access per 4 cycles.
- reqReady=0 in HI, LO and RESP. reqValid is ignored in those states; the core must hold the request.
- memWriteEn is asserted only in HI and LO of a store, never during reset or IDLE.
- respData holds its value until the next RESP.
- Reset during HI or LO aborts the access immediately:
  - memWriteEn drops asynchronously.
  - A partially written word (high byte only) is permitted.
  - No response is produced.

Optional Feature:
- Macro: RISC16_MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with reqAddr[0]=1 performs no memory transfer; memWriteEn stays 0.
  - FSM goes IDLE to RESP directly, with respValid=1, respError=1, respData=0. Latency is 1 cycle.
- Undefined:
  - Odd addresses are accessed normally (addr, addr+1).
  - respError is constantly 0.

Test Plan:
- Reset mid-store: rst pulsed during HI -> memWriteEn=0 immediately; reqReady=1; respValid=0 thereafter.
- Store 0xBEEF at 0x0010 -> memory bytes [0x10]=0xBE, [0x11]=0xEF; respValid pulses 3 cycles after accept; respData=0.
- Load from 0x0010 after that store -> respData=0xBEEF, respValid for exactly 1 cycle.
- Wrap: store 0x1234 at 0xFFFF (macro undefined) -> [0xFFFF]=0x12, [0x0000]=0x34; a load from 0xFFFF returns 0x1234.
- Back-to-back: reqValid held high for two loads -> second accept only after RESP; reqReady low for 3 cycles each time.
- Macro defined, load from 0x0011 -> respError=1, respData=0 one cycle after accept; memWriteEn never asserted; memory unchanged.
